dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters.
- Master 0 is the core load/store path (ALU result as address, register read port 2 as write data).
- Master 1 is a DMA/debug loader port.
- Round-robin arbitration, one outstanding transaction at a time, fixed-latency read return. Sits between the core datapath and the data memory instance in the top level.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 1, memory read latency in cycles (legal 1..4; mem_rdata valid LAT cycles after the read command cycle)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
m0_req  input  1  core request, held until m0_gnt
m0_we  input  1  core write enable (1=store, 0=load)
m0_addr  input  AW  core byte address
m0_wdata  input  DW  core store data
m0_gnt  output  1  core request accepted this cycle
m0_rvalid  output  1  core load data valid this cycle
m0_rdata  output  DW  core load data
m1_req  input  1  DMA request, held until m1_gnt
m1_we  input  1  DMA write enable
m1_addr  input  AW  DMA byte address
m1_wdata  input  DW  DMA write data
m1_gnt  output  1  DMA request accepted this cycle
m1_rvalid  output  1  DMA read data valid this cycle
m1_rdata  output  DW  DMA read data
mem_en  output  1  memory command strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
busy  output  1  read in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk; reset rstn asynchronous active-low. All flops clear immediately on rstn=0.
- Reset values: state=IDLE, cnt=0, owner=0, last_grant=1 (master 0 wins the first tie). While rstn=0, all outputs are 0, including combinational gnt and mem_en.
- States: IDLE, RD_WAIT.
- IDLE:
  - No req: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - One req: that master is granted.
  - Both req: grant the master not equal to last_grant.
- Grant cycle (cycle 0):
  - mX_gnt=1, combinational.
  - mem_en=1; mem_we/mem_addr/mem_wdata = granted master's inputs, passed through.
  - last_grant<=X at the clock edge.
- Write grant: completes in cycle 0; state stays IDLE. Back-to-back writes are possible every cycle.
- Read grant: owner<=X, cnt<=0, state<=RD_WAIT.
- RD_WAIT:
  - No grants; mem_en=0; cnt increments each cycle.
  - In cycle LAT, relative to the grant cycle, m{owner}_rvalid=1 for exactly one cycle; state<=IDLE at the end of that cycle.
  - The next grant is possible in cycle LAT+1. Read throughput is one per LAT+1 cycles.
- m0_rdata and m1_rdata = mem_rdata at all times; only rvalid qualifies. The non-owner's rvalid is always 0.
- gnt and rvalid are never asserted to the same master in the same cycle.
- Requester rules:
  - A requester must hold req/we/addr/wdata stable until gnt.
  - Deasserting req before gnt is allowed and has no side effect.
  - A request raised while busy=1 waits; no gnt is issued during RD_WAIT.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1. Neither master is ever starved by more than one transaction.
- cnt width: clog2(LAT+1). The RD_WAIT exit compare is cnt==LAT-1 at the clock edge.
- busy = (state==RD_WAIT), registered.
- Reset mid-read: the in-flight read is dropped, no rvalid is issued, last_grant returns to 1.
- The arbiter performs no address decode or alignment check.

Test Plan:
- Reset, then m0 write only (addr 0x10, wdata 0xDEADBEEF) -> m0_gnt=1, mem_en=1, mem_we=1, mem_addr=0x10 in the same cycle; busy stays 0.
- m0 read addr 0x10, LAT=1 -> gnt in cycle 0; m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle 1; busy=1 for that cycle only; m1_rvalid stays 0.
- Both masters request reads continuously from reset, LAT=2 -> grant order m0,m1,m0,m1, one grant every 3 cycles; each rvalid goes to the correct master 2 cycles after its grant.
- m1 raises req during an m0 read in RD_WAIT -> m1_gnt is withheld until the cycle after m0_rvalid, then granted.
- rstn pulsed low during RD_WAIT (LAT=3) -> no rvalid; all outputs 0 immediately; after release, a simultaneous m0/m1 request grants m0.
- Back-to-back m1 writes for 4 cycles (addr 0x0, 0x4, 0x8, 0xC) -> m1_gnt and mem_en high on 4 consecutive cycles with matching addresses; busy never asserts.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the memory port and the busy flag around dmem_arbiter.
// Handshake: a requester holds req/we/addr/wdata until gnt; gnt is the accept cycle; rvalid qualifies rdata.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (m0) and a DMA/debug port (m1).
// One transaction at a time; reads hold the arbiter in RD_WAIT until the fixed-latency data returns.
module dmem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    dmem_arbiter_if.slave    bus,
    output logic             o_dbg_state
);
    localparam int              CW       = $clog2(LAT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(LAT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_last_grant, w_last_grant_nxt;

    logic          w_sel1;
    logic          w_gnt0, w_gnt1;
    logic          w_rv0, w_rv1;
    logic          w_mem_en, w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_gnt0           = 1'b0;
        w_gnt1           = 1'b0;
        w_rv0            = 1'b0;
        w_rv1            = 1'b0;
        w_mem_en         = 1'b0;
        w_mem_we         = 1'b0;
        w_mem_addr       = '0;
        w_mem_wdata      = '0;
        // On a tie, m1 wins only if m0 took the previous grant.
        w_sel1           = bus.m1_req & (~bus.m0_req | ~r_last_grant);

        case (r_state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    w_gnt0           = ~w_sel1;
                    w_gnt1           = w_sel1;
                    w_mem_en         = 1'b1;
                    w_mem_we         = w_sel1 ? bus.m1_we    : bus.m0_we;
                    w_mem_addr       = w_sel1 ? bus.m1_addr  : bus.m0_addr;
                    w_mem_wdata      = w_sel1 ? bus.m1_wdata : bus.m0_wdata;
                    w_last_grant_nxt = w_sel1;
                    if (!w_mem_we) begin
                        w_owner_nxt = w_sel1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // cnt is 0 in the first wait cycle, so cnt==LAT-1 lands on cycle LAT after the grant.
                if (r_cnt == CNT_LAST) begin
                    w_rv0       = ~r_owner;
                    w_rv1       = r_owner;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.m0_gnt    = rstn & w_gnt0;
    assign bus.m1_gnt    = rstn & w_gnt1;
    assign bus.m0_rvalid = rstn & w_rv0;
    assign bus.m1_rvalid = rstn & w_rv1;
    assign bus.m0_rdata  = rstn ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = rstn ? bus.mem_rdata : '0;
    assign bus.mem_en    = rstn & w_mem_en;
    assign bus.mem_we    = rstn & w_mem_we;
    assign bus.mem_addr  = rstn ? w_mem_addr  : '0;
    assign bus.mem_wdata = rstn ? w_mem_wdata : '0;
    assign bus.busy      = (r_state == RD_WAIT);
    assign o_dbg_state   = (r_state == RD_WAIT);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: LAT=1 vector table with a small memory model, LAT=2 fairness run,
// LAT=3 reset during a read, and back-to-back DMA writes.
module tb_dmem_arbiter;
    logic clk;
    logic rstn;
    logic dbg1, dbg2, dbg3;
    int   total;
    int   bad;

    dmem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) b2 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) b3 ();

    dmem_arbiter #(.AW(32), .DW(32), .LAT(1)) u1 (.clk(clk), .rstn(rstn), .bus(b1.slave), .o_dbg_state(dbg1));
    dmem_arbiter #(.AW(32), .DW(32), .LAT(2)) u2 (.clk(clk), .rstn(rstn), .bus(b2.slave), .o_dbg_state(dbg2));
    dmem_arbiter #(.AW(32), .DW(32), .LAT(3)) u3 (.clk(clk), .rstn(rstn), .bus(b3.slave), .o_dbg_state(dbg3));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model for the LAT=1 instance ----------------
    logic [31:0] mem1 [16];
    logic [31:0] rd1;
    initial begin
        for (int i = 0; i < 16; i++) mem1[i] = 32'h0;
        rd1 = 32'h0;
    end
    always @(posedge clk) begin
        if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[5:2]] <= b1.mem_wdata;
        rd1 <= mem1[b1.mem_addr[5:2]];
    end
    assign b1.mem_rdata = rd1;
    assign b2.mem_rdata = 32'hA5A5_0002;
    assign b3.mem_rdata = 32'hA5A5_0003;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.m0_req = 0; b1.m0_we = 0; b1.m0_addr = 0; b1.m0_wdata = 0;
        b1.m1_req = 0; b1.m1_we = 0; b1.m1_addr = 0; b1.m1_wdata = 0;
        b2.m0_req = 0; b2.m0_we = 0; b2.m0_addr = 0; b2.m0_wdata = 0;
        b2.m1_req = 0; b2.m1_we = 0; b2.m1_addr = 0; b2.m1_wdata = 0;
        b3.m0_req = 0; b3.m0_we = 0; b3.m0_addr = 0; b3.m0_wdata = 0;
        b3.m1_req = 0; b3.m1_we = 0; b3.m1_addr = 0; b3.m1_wdata = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // ---------------- vector table (LAT=1) ----------------
    typedef struct {
        string       name;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, en, we;
        logic [31:0] addr, wd;
        logic        v0, v1, bsy, ck;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string name,
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic g0, input logic g1, input logic en, input logic we,
        input logic [31:0] addr, input logic [31:0] wd,
        input logic v0, input logic v1, input logic bsy, input logic ck, input logic [31:0] rd);
        vec_t v;
        v.name = name; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.v0 = v0; v.v1 = v1; v.bsy = bsy; v.ck = ck; v.rd = rd;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        idle_inputs();

        // Reset state: requests present, yet every output must stay low.
        b1.m0_req = 1; b1.m0_we = 1; b1.m0_addr = 32'h10; b1.m0_wdata = 32'h1;
        #2;
        chk("rst_m0_gnt",  b1.m0_gnt,   0);
        chk("rst_mem_en",  b1.mem_en,   0);
        chk("rst_mem_we",  b1.mem_we,   0);
        chk("rst_mem_addr", b1.mem_addr, 0);
        chk("rst_busy",    b1.busy,     0);
        chk("rst_dbg",     dbg1,        0);
        idle_inputs();
        step();
        rstn = 1'b1;

        //             name        r0 w0 a0      d0            r1 w1 a1     d1            g0 g1 en we addr   wd            v0 v1 bsy ck rd
        vecs.push_back(mk("m0_wr",    1, 1, 'h10, 'hDEADBEEF, 0, 0, 0,    0,            1, 0, 1, 1, 'h10, 'hDEADBEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk("m0_rd",    1, 0, 'h10, 0,          0, 0, 0,    0,            1, 0, 1, 0, 'h10, 0,          0, 0, 0, 0, 0));
        vecs.push_back(mk("m0_rret",  0, 0, 0,    0,          0, 0, 0,    0,            0, 0, 0, 0, 0,    0,          1, 0, 1, 1, 'hDEADBEEF));
        vecs.push_back(mk("idle0",    0, 0, 0,    0,          0, 0, 0,    0,            0, 0, 0, 0, 0,    0,          0, 0, 0, 0, 0));
        vecs.push_back(mk("m1_wr",    0, 0, 0,    0,          1, 1, 'h20, 'h12345678,   0, 1, 1, 1, 'h20, 'h12345678, 0, 0, 0, 0, 0));
        vecs.push_back(mk("tie_m0",   1, 1, 'h24, 'h11111111, 1, 1, 'h28, 'h22222222,   1, 0, 1, 1, 'h24, 'h11111111, 0, 0, 0, 0, 0));
        vecs.push_back(mk("tie_m1",   1, 1, 'h2C, 'h33333333, 1, 1, 'h28, 'h22222222,   0, 1, 1, 1, 'h28, 'h22222222, 0, 0, 0, 0, 0));
        vecs.push_back(mk("m0_held",  1, 1, 'h2C, 'h33333333, 0, 0, 0,    0,            1, 0, 1, 1, 'h2C, 'h33333333, 0, 0, 0, 0, 0));
        vecs.push_back(mk("m1_rd",    0, 0, 0,    0,          1, 0, 'h20, 0,            0, 1, 1, 0, 'h20, 0,          0, 0, 0, 0, 0));
        vecs.push_back(mk("m1_rret",  0, 0, 0,    0,          0, 0, 0,    0,            0, 0, 0, 0, 0,    0,          0, 1, 1, 1, 'h12345678));
        vecs.push_back(mk("both_rd",  1, 0, 'h24, 0,          1, 0, 'h28, 0,            1, 0, 1, 0, 'h24, 0,          0, 0, 0, 0, 0));
        vecs.push_back(mk("m1_wait",  0, 0, 0,    0,          1, 0, 'h28, 0,            0, 0, 0, 0, 0,    0,          1, 0, 1, 1, 'h11111111));
        vecs.push_back(mk("m1_after", 0, 0, 0,    0,          1, 0, 'h28, 0,            0, 1, 1, 0, 'h28, 0,          0, 0, 0, 0, 0));
        vecs.push_back(mk("m1_rret2", 0, 0, 0,    0,          0, 0, 0,    0,            0, 0, 0, 0, 0,    0,          0, 1, 1, 1, 'h22222222));
        vecs.push_back(mk("idle1",    0, 0, 0,    0,          0, 0, 0,    0,            0, 0, 0, 0, 0,    0,          0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            b1.m0_req = vecs[i].r0; b1.m0_we = vecs[i].w0; b1.m0_addr = vecs[i].a0; b1.m0_wdata = vecs[i].d0;
            b1.m1_req = vecs[i].r1; b1.m1_we = vecs[i].w1; b1.m1_addr = vecs[i].a1; b1.m1_wdata = vecs[i].d1;
            @(negedge clk);
            chk({vecs[i].name, ".m0_gnt"},    b1.m0_gnt,    vecs[i].g0);
            chk({vecs[i].name, ".m1_gnt"},    b1.m1_gnt,    vecs[i].g1);
            chk({vecs[i].name, ".mem_en"},    b1.mem_en,    vecs[i].en);
            chk({vecs[i].name, ".mem_we"},    b1.mem_we,    vecs[i].we);
            chk({vecs[i].name, ".mem_addr"},  b1.mem_addr,  vecs[i].addr);
            chk({vecs[i].name, ".mem_wdata"}, b1.mem_wdata, vecs[i].wd);
            chk({vecs[i].name, ".m0_rvalid"}, b1.m0_rvalid, vecs[i].v0);
            chk({vecs[i].name, ".m1_rvalid"}, b1.m1_rvalid, vecs[i].v1);
            chk({vecs[i].name, ".busy"},      b1.busy,      vecs[i].bsy);
            if (vecs[i].ck) begin
                chk({vecs[i].name, ".m0_rdata"}, b1.m0_rdata, vecs[i].rd);
                chk({vecs[i].name, ".m1_rdata"}, b1.m1_rdata, vecs[i].rd);
            end
            step();
        end
        idle_inputs();

        // LAT=2: both masters read continuously from reset; grant every 3 cycles, alternating.
        rstn = 1'b0;
        b2.m0_req = 1; b2.m0_we = 0; b2.m0_addr = 32'h100;
        b2.m1_req = 1; b2.m1_we = 0; b2.m1_addr = 32'h200;
        step();
        step();
        rstn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("l2_c%0d.m0_gnt", c),    b2.m0_gnt,    (c % 6 == 0) ? 1 : 0);
            chk($sformatf("l2_c%0d.m1_gnt", c),    b2.m1_gnt,    (c % 6 == 3) ? 1 : 0);
            chk($sformatf("l2_c%0d.m0_rvalid", c), b2.m0_rvalid, (c % 6 == 2) ? 1 : 0);
            chk($sformatf("l2_c%0d.m1_rvalid", c), b2.m1_rvalid, (c % 6 == 5) ? 1 : 0);
            chk($sformatf("l2_c%0d.busy", c),      b2.busy,      (c % 3 == 0) ? 0 : 1);
            if (c % 6 == 0) chk($sformatf("l2_c%0d.mem_addr", c), b2.mem_addr, 32'h100);
            if (c % 6 == 3) chk($sformatf("l2_c%0d.mem_addr", c), b2.mem_addr, 32'h200);
            if (c % 6 == 2) chk($sformatf("l2_c%0d.m0_rdata", c), b2.m0_rdata, 32'hA5A5_0002);
            step();
        end
        idle_inputs();

        // LAT=3: reset pulsed in the middle of an m0 read.
        do_reset();
        b3.m0_req = 1; b3.m0_we = 0; b3.m0_addr = 32'h40;
        @(negedge clk);
        chk("l3_grant", b3.m0_gnt, 1);
        step();
        b3.m0_req = 0;
        @(negedge clk);
        chk("l3_busy_c1", b3.busy, 1);
        step();
        b3.m0_req = 1; b3.m1_req = 1; b3.m1_addr = 32'h44;
        #2;
        rstn = 1'b0;
        #1;
        chk("l3_rst_busy",   b3.busy,      0);
        chk("l3_rst_m0_gnt", b3.m0_gnt,    0);
        chk("l3_rst_m1_gnt", b3.m1_gnt,    0);
        chk("l3_rst_mem_en", b3.mem_en,    0);
        chk("l3_rst_maddr",  b3.mem_addr,  0);
        chk("l3_rst_rdata",  b3.m0_rdata,  0);
        step();
        @(negedge clk);
        chk("l3_no_rvalid0", b3.m0_rvalid, 0);
        chk("l3_no_rvalid1", b3.m1_rvalid, 0);
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("l3_tie_m0_gnt", b3.m0_gnt,   1);
        chk("l3_tie_m1_gnt", b3.m1_gnt,   0);
        chk("l3_tie_addr",   b3.mem_addr, 32'h40);
        step();
        idle_inputs();

        // LAT=1: four back-to-back m1 writes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = $urandom_range(32'h0000_FFFF, 0) | 32'h5A00_0000;
            b1.m1_req = 1; b1.m1_we = 1; b1.m1_addr = 32'(4 * i); b1.m1_wdata = d;
            @(negedge clk);
            chk($sformatf("b2b%0d.m1_gnt", i),    b1.m1_gnt,    1);
            chk($sformatf("b2b%0d.mem_en", i),    b1.mem_en,    1);
            chk($sformatf("b2b%0d.mem_we", i),    b1.mem_we,    1);
            chk($sformatf("b2b%0d.mem_addr", i),  b1.mem_addr,  32'(4 * i));
            chk($sformatf("b2b%0d.mem_wdata", i), b1.mem_wdata, d);
            chk($sformatf("b2b%0d.busy", i),      b1.busy,      0);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("b2b_end.busy",   b1.busy,   0);
        chk("b2b_end.mem_en", b1.mem_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
